pipe_reg_elastic: RTL and testbench

//  Parametrised successor to the fixed-delay pipe register: DEPTH-stage, WIDTH-bit

---
 rtl/pipe_reg_elastic.sv | 129 ++++++++++++
 tb/tb_pipe_reg_elastic.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_elastic
// Description : DEPTH-stage, WIDTH-bit elastic pipeline with per-stage valid
//               bits, valid/ready handshake on both sides, bubble collapse,
//               upstream back-pressure, synchronous flush and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] valid_src;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] data_src [DEPTH];
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             in_xfer;
    logic             out_xfer;

    // Advance chain runs from the output back to stage 0; a stage may hand on
    // when its successor is empty or is itself handing on.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~valid_q[i+1] | adv[i+1];
        end
        load = ~valid_q | adv;
    end

    always_comb begin
        valid_src[0] = in_valid;
        data_src[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_src[i] = valid_q[i-1];
            data_src[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = (load & valid_src) | (~load & valid_q);
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    generate
        if (CLR_DATA != 0) begin : g_data_clr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (load[i]) begin
                            data_q[i] <= data_src[i];
                        end
                    end
                end
            end
        end else begin : g_data_noclr
            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (load[i]) begin
                        data_q[i] <= data_src[i];
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = load[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Count tracks popcount(valid_q) by mirroring the two boundary transfers.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_elastic
// Description : Bench for pipe_reg_elastic at DEPTH 4 (CLR_DATA=1), 1 and 7,
//               checked against a queue-of-words model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_pipe_reg_elastic;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl   [NDUT];
    logic       iv   [NDUT];
    logic       ir   [NDUT];
    logic       ov   [NDUT];
    logic       ordy [NDUT];
    logic [7:0] id   [NDUT];
    logic [7:0] od   [NDUT];
    logic [2:0] occ  [NDUT];

    int nchk  = 0;
    int nfail = 0;

    // Model: each pipe is an ordered list of words (oldest first) with the
    // stage each word currently sits in.
    int         dep  [NDUT] = '{4, 1, 7};
    logic [7:0] mw   [NDUT][8];
    int         mpos [NDUT][8];
    int         mn   [NDUT] = '{0, 0, 0};
    logic [7:0] seq  [NDUT] = '{8'h00, 8'h40, 8'h80};

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            pipe_reg_elastic #(
                .WIDTH   (8),
                .DEPTH   (g == 0 ? 4 : (g == 1 ? 1 : 7)),
                .CLR_DATA(g == 0 ? 1 : 0),
                .CNT_W   (3)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .flush    (fl[g]),
                .in_data  (id[g]),
                .in_valid (iv[g]),
                .in_ready (ir[g]),
                .out_data (od[g]),
                .out_valid(ov[g]),
                .out_ready(ordy[g]),
                .occupancy(occ[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_pops(input int k);
        return mn[k] > 0 && mpos[k][0] == dep[k] - 1 && ordy[k];
    endfunction

    // Stage the youngest word would occupy after this edge (dep = none left).
    function automatic int m_youngest_after(input int k);
        int lim;
        int p;
        lim = dep[k] - 1;
        p   = dep[k];
        for (int j = (m_pops(k) ? 1 : 0); j < mn[k]; j++) begin
            p   = (mpos[k][j] + 1 < lim) ? mpos[k][j] + 1 : lim;
            lim = p - 1;
        end
        return p;
    endfunction

    function automatic logic m_in_ready(input int k);
        return !fl[k] && m_youngest_after(k) != 0;
    endfunction

    function automatic logic m_out_valid(input int k);
        return !fl[k] && mn[k] > 0 && mpos[k][0] == dep[k] - 1;
    endfunction

    initial begin : model_proc
        bit acc;
        int lim;
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < NDUT; k++) begin
                if (rst || fl[k]) begin
                    mn[k] = 0;
                end else begin
                    acc = iv[k] && m_in_ready(k);
                    if (m_pops(k)) begin
                        for (int j = 0; j < mn[k] - 1; j++) begin
                            mw[k][j]   = mw[k][j+1];
                            mpos[k][j] = mpos[k][j+1];
                        end
                        mn[k]--;
                    end
                    lim = dep[k] - 1;
                    for (int j = 0; j < mn[k]; j++) begin
                        mpos[k][j] = (mpos[k][j] + 1 < lim) ? mpos[k][j] + 1 : lim;
                        lim        = mpos[k][j] - 1;
                    end
                    if (acc) begin
                        mw[k][mn[k]]   = id[k];
                        mpos[k][mn[k]] = 0;
                        mn[k]++;
                    end
                end
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NDUT; k++) begin
                    chk($sformatf("dut%0d in_ready", k), 32'(ir[k]), 32'(m_in_ready(k)));
                    chk($sformatf("dut%0d out_valid", k), 32'(ov[k]), 32'(m_out_valid(k)));
                    chk($sformatf("dut%0d occupancy", k), 32'(occ[k]), 32'(mn[k]));
                    if (m_out_valid(k)) begin
                        chk($sformatf("dut%0d out_data", k), 32'(od[k]), 32'(mw[k][0]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim_proc
        for (int k = 0; k < NDUT; k++) begin
            fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; id[k] = 8'h00;
        end
        #7;
        chk("reset out_valid", 32'(ov[0]), 0);
        chk("reset occupancy", 32'(occ[0]), 0);
        chk("reset in_ready", 32'(ir[0]), 1);
        #1 rst = 1'b0;
        tick();

        // Stream: word n accepted at edge n, visible after edge n+3
        ordy[0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            id[0] = 8'(n); iv[0] = 1'b1;
            tick();
            chk("stream in_ready", 32'(ir[0]), 1);
            if (n >= 4) chk("stream out_data", 32'(od[0]), 32'(n - 3));
            else        chk("stream latency out_valid", 32'(ov[0]), 0);
        end
        iv[0] = 1'b0;
        repeat (4) tick();
        chk("stream drained occupancy", 32'(occ[0]), 0);

        // Stall with a full pipe
        ordy[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            id[0] = 8'hA0 + 8'(j); iv[0] = 1'b1;
            tick();
        end
        id[0] = 8'hA4;
        chk("stall occupancy", 32'(occ[0]), 4);
        chk("stall in_ready", 32'(ir[0]), 0);
        chk("stall out_data", 32'(od[0]), 32'hA0);
        tick();
        chk("stall held out_data", 32'(od[0]), 32'hA0);
        ordy[0] = 1'b1;
        #1 chk("release in_ready", 32'(ir[0]), 1);
        tick();
        chk("release out_data", 32'(od[0]), 32'hA1);
        chk("release occupancy", 32'(occ[0]), 4);
        iv[0] = 1'b0;
        repeat (4) tick();

        // Bubble collapse
        ordy[0] = 1'b0;
        id[0] = 8'hB0; iv[0] = 1'b1; tick();
        iv[0] = 1'b0; tick();
        id[0] = 8'hB1; iv[0] = 1'b1; tick();
        iv[0] = 1'b0; tick(); tick(); tick();
        chk("bubble occupancy", 32'(occ[0]), 2);
        chk("bubble out_data", 32'(od[0]), 32'hB0);
        ordy[0] = 1'b1;
        tick();
        chk("bubble b2b out_valid", 32'(ov[0]), 1);
        chk("bubble b2b out_data", 32'(od[0]), 32'hB1);
        tick();
        chk("bubble empty out_valid", 32'(ov[0]), 0);

        // Flush with three words held, one at the output
        ordy[0] = 1'b0;
        id[0] = 8'hC0; iv[0] = 1'b1; tick();
        iv[0] = 1'b0; repeat (3) tick();
        id[0] = 8'hC1; iv[0] = 1'b1; tick();
        id[0] = 8'hC2; tick();
        chk("preflush occupancy", 32'(occ[0]), 3);
        chk("preflush out_valid", 32'(ov[0]), 1);
        fl[0] = 1'b1; ordy[0] = 1'b1; id[0] = 8'hC3;
        #1;
        chk("flush in_ready", 32'(ir[0]), 0);
        chk("flush out_valid", 32'(ov[0]), 0);
        tick();
        fl[0] = 1'b0; iv[0] = 1'b0;
        #1;
        chk("postflush occupancy", 32'(occ[0]), 0);
        chk("postflush out_valid", 32'(ov[0]), 0);
        chk("postflush in_ready", 32'(ir[0]), 1);
        tick();

        // Asynchronous reset between edges
        ordy[0] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            id[0] = 8'hD0 + 8'(j); iv[0] = 1'b1;
            tick();
        end
        chk("prereset out_valid", 32'(ov[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(ov[0]), 0);
        chk("async reset occupancy", 32'(occ[0]), 0);
        chk("async reset out_data", 32'(od[0]), 0);
        #1 rst = 1'b0;
        iv[0] = 1'b0;
        tick();

        // Random traffic on all three depths
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                iv[k]   = $urandom_range(0, 3) != 0;
                ordy[k] = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                fl[k]   = $urandom_range(0, 63) == 0;
                id[k]   = seq[k];
                seq[k]  = seq[k] + 8'd1;
            end
            tick();
        end
        for (int k = 0; k < NDUT; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0;
        end
        repeat (10) tick();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d final occupancy", k), 32'(occ[k]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
